// File: rtl/cm0ik_misc_delay_sched.sv
// Round-robin scheduler sharing one countdown delay engine between NREQ requesters.
// Optional abort support is enabled by defining CM0IK_DELAY_SCHED_ABORT_EN.
module cm0ik_misc_delay_sched #(
  parameter int NREQ = 4,
  parameter int CW   = 8
) (
  input  logic               fclk,
  input  logic               hresetn,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*CW-1:0] dly,
`ifdef CM0IK_DELAY_SCHED_ABORT_EN
  input  logic               abort,
  output logic               aborted,
`endif
  output logic [NREQ-1:0]    ack,
  output logic [NREQ-1:0]    evt,
  output logic               busy,
  output logic [2:0]         cur_id
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIRE} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_ptr;
  logic [2:0]      r_cur_id;
  logic [NREQ-1:0] r_ack;
  logic [NREQ-1:0] r_evt;
  logic            r_busy;
`ifdef CM0IK_DELAY_SCHED_ABORT_EN
  logic            r_aborted;
`endif

  logic            w_gnt_vld;
  logic [2:0]      w_gnt_id;
  logic [CW-1:0]   w_gnt_dly;
  logic [2:0]      w_next_ptr;
  logic [NREQ-1:0] w_gnt_oh;
  logic [NREQ-1:0] w_cur_oh;

  // First set bit of r at or above p, wrapping; descending scan lets the nearest index win.
  function automatic logic [2:0] rr_pick(input logic [NREQ-1:0] r, input logic [2:0] p);
    logic [2:0]      pick;
    logic [NREQ-1:0] rot;
    int              idx;
    pick = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(p) + k) % NREQ;
      rot = r >> idx;
      if (rot[0]) pick = 3'(idx);
    end
    return pick;
  endfunction

  always_comb begin
    // NOTE: every combinational signal gets a value on every path, so no latch is inferred.
    w_gnt_vld  = |req;
    w_gnt_id   = rr_pick(req, r_ptr);
    w_gnt_dly  = CW'(dly >> (int'(w_gnt_id) * CW));
    w_next_ptr = (w_gnt_id == 3'(NREQ - 1)) ? 3'd0 : w_gnt_id + 3'd1;
    w_gnt_oh   = {{(NREQ-1){1'b0}}, 1'b1} << w_gnt_id;
    w_cur_oh   = {{(NREQ-1){1'b0}}, 1'b1} << r_cur_id;
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge fclk) begin
    if (!hresetn) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_ptr     <= '0;
      r_cur_id  <= '0;
      r_ack     <= '0;
      r_evt     <= '0;
      r_busy    <= 1'b0;
`ifdef CM0IK_DELAY_SCHED_ABORT_EN
      r_aborted <= 1'b0;
`endif
    end else begin
      r_ack     <= '0;
      r_evt     <= '0;
`ifdef CM0IK_DELAY_SCHED_ABORT_EN
      r_aborted <= 1'b0;
`endif
      unique case (r_state)
        S_IDLE: begin
          if (w_gnt_vld) begin
            r_ack    <= w_gnt_oh;
            r_cnt    <= w_gnt_dly;
            r_cur_id <= w_gnt_id;
            r_ptr    <= w_next_ptr;
            r_busy   <= 1'b1;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
`ifdef CM0IK_DELAY_SCHED_ABORT_EN
          // Abort wins over the terminal count in the same cycle.
          if (abort) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_aborted <= 1'b1;
            r_busy    <= 1'b0;
          end else
`endif
          if (r_cnt == '0) begin
            r_evt   <= w_cur_oh;
            r_state <= S_FIRE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_FIRE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ack     = r_ack;
  assign evt     = r_evt;
  assign busy    = r_busy;
  assign cur_id  = r_cur_id;
`ifdef CM0IK_DELAY_SCHED_ABORT_EN
  assign aborted = r_aborted;
`endif

endmodule

// File: tb/tb_cm0ik_misc_delay_sched.sv
// Self-checking bench: directed scenarios plus random traffic against a timeline-based reference model.
module tb_cm0ik_misc_delay_sched;

  localparam int NREQ = 4;
  localparam int CW   = 8;

  logic               fclk    = 1'b0;
  logic               hresetn = 1'b0;
  logic [NREQ-1:0]    req     = '0;
  logic [NREQ*CW-1:0] dly     = '0;
  logic [NREQ-1:0]    ack;
  logic [NREQ-1:0]    evt;
  logic               busy;
  logic [2:0]         cur_id;
`ifdef CM0IK_DELAY_SCHED_ABORT_EN
  logic               abort   = 1'b0;
  logic               aborted;
`endif

  cm0ik_misc_delay_sched #(.NREQ(NREQ), .CW(CW)) dut (
    .fclk   (fclk),
    .hresetn(hresetn),
    .req    (req),
    .dly    (dly),
`ifdef CM0IK_DELAY_SCHED_ABORT_EN
    .abort  (abort),
    .aborted(aborted),
`endif
    .ack    (ack),
    .evt    (evt),
    .busy   (busy),
    .cur_id (cur_id)
  );

  always #5 fclk = ~fclk;

  int checks = 0;
  int errors = 0;
  int n      = 0;
  bit chk_en = 0;
  bit hold_req = 0;

  // Reference model: one transaction described by its ack cycle, delay and id.
  bit m_active = 0;
  int m_t = 0, m_d = 0, m_id = 0, m_cur = 0, m_ptr = 0, m_ab_at = -10;

  int ack_cyc [NREQ];
  int evt_cyc [NREQ];
  int log_id  [$];
  int log_cyc [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, n);
    end
  endtask

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic set_dly(input int i, input int v);
    dly[i*CW +: CW] = CW'(v);
  endtask

  // Predicts the edge that ends cycle n from the inputs currently applied.
  task automatic model_edge();
    bit idle, run, ab, found;
    int g, idx;
    ab = 0;
`ifdef CM0IK_DELAY_SCHED_ABORT_EN
    ab = abort;
`endif
    if (!hresetn) begin
      m_active = 0; m_ptr = 0; m_cur = 0; m_ab_at = -10; chk_en = 1;
    end else begin
      idle = !m_active || (n >= m_t + m_d + 2);
      run  = m_active && (n >= m_t) && (n <= m_t + m_d);
      if (idle && req != '0) begin
        found = 0; g = 0;
        for (int k = 0; k < NREQ; k++) begin
          idx = (m_ptr + k) % NREQ;
          if (!found && req[idx]) begin found = 1; g = idx; end
        end
        m_active = 1; m_t = n + 1; m_id = g; m_cur = g;
        m_d = int'(dly[g*CW +: CW]);
        m_ptr = (g + 1) % NREQ;
      end else if (run && ab) begin
        m_active = 0; m_ab_at = n + 1;
      end
    end
  endtask

  task automatic step();
    logic [NREQ-1:0] e_ack, e_evt;
    logic            e_busy;
    @(negedge fclk);
    if (chk_en) begin
      e_ack  = (m_active && n == m_t) ? onehot(m_id) : '0;
      e_evt  = (m_active && n == m_t + m_d + 1) ? onehot(m_id) : '0;
      e_busy = m_active && (n >= m_t) && (n <= m_t + m_d + 1);
      check("ack", 32'(ack), 32'(e_ack));
      check("evt", 32'(evt), 32'(e_evt));
      check("busy", 32'(busy), 32'(e_busy));
      check("cur_id", 32'(cur_id), 32'(m_cur));
`ifdef CM0IK_DELAY_SCHED_ABORT_EN
      check("aborted", 32'(aborted), 32'(n == m_ab_at));
`endif
    end
    for (int i = 0; i < NREQ; i++) begin
      if (ack[i] === 1'b1) begin
        ack_cyc[i] = n; log_id.push_back(i); log_cyc.push_back(n);
      end
      if (evt[i] === 1'b1) evt_cyc[i] = n;
    end
    model_edge();
    @(posedge fclk);
    #1;
    n++;
    if (!hold_req) req = req & ~ack;
  endtask

  task automatic wait_ack(output int id);
    id = -1;
    for (int i = 0; i < 300; i++) begin
      if (ack != '0) break;
      step();
    end
    check("ack_timeout", 32'(ack != '0), 32'd1);
    for (int i = 0; i < NREQ; i++) if (ack[i] === 1'b1) id = i;
  endtask

  task automatic do_reset(input int cycles);
    hresetn = 1'b0;
    repeat (cycles) step();
    hresetn = 1'b1;
  endtask

  initial begin
    int id;
    for (int i = 0; i < NREQ; i++) begin ack_cyc[i] = -1000; evt_cyc[i] = -1000; end

    // Reset, then a quiet idle period.
    do_reset(3);
    repeat (20) step();
    check("idle_busy", 32'(busy), 32'd0);

    // Single request with delay 5.
    set_dly(2, 5);
    req = 4'b0100;
    wait_ack(id);
    check("t2_id", 32'(id), 32'd2);
    repeat (7) step();
    check("t2_latency", 32'(evt_cyc[2] - ack_cyc[2]), 32'd6);

    // Zero and maximum delays.
    set_dly(0, 0);
    req = 4'b0001;
    wait_ack(id);
    repeat (3) step();
    check("t3_zero", 32'(evt_cyc[0] - ack_cyc[0]), 32'd1);
    set_dly(1, 255);
    req = 4'b0010;
    wait_ack(id);
    repeat (258) step();
    check("t3_max", 32'(evt_cyc[1] - ack_cyc[1]), 32'd256);

    // Round-robin with all requests held high.
    do_reset(1);
    for (int i = 0; i < NREQ; i++) set_dly(i, 1);
    log_id.delete(); log_cyc.delete();
    hold_req = 1;
    req = 4'b1111;
    repeat (20) step();
    req = '0;
    hold_req = 0;
    repeat (6) step();
    check("t4_count", 32'(log_id.size() >= 5), 32'd1);
    if (log_id.size() >= 5) begin
      for (int j = 0; j < 5; j++) check("t4_order", 32'(log_id[j]), 32'(j % NREQ));
      for (int j = 1; j < 5; j++) check("t4_spacing", 32'(log_cyc[j] - log_cyc[j-1]), 32'd4);
    end

    // Reset in the middle of a countdown.
    set_dly(3, 10);
    req = 4'b1000;
    wait_ack(id);
    repeat (4) step();
    hresetn = 1'b0;
    step();
    hresetn = 1'b1;
    check("t5_ack_zero", 32'(ack), 32'd0);
    check("t5_busy_zero", 32'(busy), 32'd0);
    set_dly(1, 2);
    req = 4'b0010;
    wait_ack(id);
    check("t5_first", 32'(ack), 32'b0010);
    repeat (12) step();
    check("t5_no_evt3", 32'(evt_cyc[3] > ack_cyc[3]), 32'd0);

`ifdef CM0IK_DELAY_SCHED_ABORT_EN
    // Abort mid-countdown.
    set_dly(1, 8);
    req = 4'b0010;
    wait_ack(id);
    repeat (3) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t6_aborted", 32'(aborted), 32'd1);
    check("t6_busy", 32'(busy), 32'd0);
    repeat (12) step();
    check("t6_no_evt", 32'(evt_cyc[1] > ack_cyc[1]), 32'd0);
    // Abort in the cycle the counter reaches zero.
    set_dly(1, 3);
    req = 4'b0010;
    wait_ack(id);
    repeat (3) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t6b_aborted", 32'(aborted), 32'd1);
    repeat (8) step();
    check("t6b_no_evt", 32'(evt_cyc[1] > ack_cyc[1]), 32'd0);
`endif

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && $urandom_range(0, 5) == 0) begin
          set_dly(i, $urandom_range(0, 12));
          req[i] = 1'b1;
        end else if ($urandom_range(0, 3) == 0) begin
          set_dly(i, $urandom_range(0, 12));
        end
      end
`ifdef CM0IK_DELAY_SCHED_ABORT_EN
      abort = ($urandom_range(0, 24) == 0);
`endif
      step();
    end
    req = '0;
`ifdef CM0IK_DELAY_SCHED_ABORT_EN
    abort = 1'b0;
`endif
    repeat (30) step();
    check("drain_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
